fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 31 +++
 rtl/next_pc_calc.sv | 36 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared fetch-stage types and instruction field constants.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam int OPCODE_W    = 6;
    localparam int FUNCT_W     = 6;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int FUNCT_MSB   = 5;
    localparam int FUNCT_LSB   = 0;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 0;
    localparam int JTARGET_MSB = 25;
    localparam int JTARGET_LSB = 0;

    function automatic logic [31:0] sign_ext_imm(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC select (JR > J > taken BNE > PC+4).
// Revision    : 1.0
// ============================================================================
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] jr_target,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        JumpSel,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic w_unused;
    assign w_unused = ^{instr[31:26], jr_target[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        if (Jump && JumpSel) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[JTARGET_MSB:JTARGET_LSB], 2'b00};
        end else if (Branch && !alu_zero) begin
            // wraps modulo 2^32 by construction
            next_pc = pc_plus4 + (sign_ext_imm(instr[IMM_MSB:IMM_LSB]) << 2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Two-state instruction fetch stage; optional watchdog enabled
//               by defining FETCH_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                Jump,
    input  logic                Branch,
    input  logic                JumpSel,
    input  logic                alu_zero,
    input  logic [31:0]         jr_target,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  funct,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                instr_valid,
    output logic                fetch_err
);

    fetch_state_t state_q, state_d;
    logic         run_q;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_fetching;

    // run_q keeps the request low until the first edge after reset release
    assign w_fetching = run_q && (state_q == FETCH);
    assign w_pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4  (w_pc_plus4),
        .instr     (instr_q),
        .jr_target (jr_target),
        .Jump      (Jump),
        .Branch    (Branch),
        .JumpSel   (JumpSel),
        .alu_zero  (alu_zero),
        .next_pc   (w_next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            FETCH: begin
                if (w_fetching && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_d    = w_next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // an ack in the expiry cycle wins: the counter only runs while unacked
    always_comb begin
        cnt_d = '0;
        err_d = 1'b0;
        if (w_fetching && !imem_ack) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign fetch_err        = 1'b0;
`endif

    assign imem_req    = w_fetching;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign pc          = pc_q;
    assign pc_plus4    = w_pc_plus4;
    assign instr_valid = (state_q == HOLD);

endmodule
`default_nettype wire
